pipe_ctrl_hazard: RTL and testbench

- Consumes the decoded control bundle produced in ID by the instruction decoder.
- Carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and branch-operand hazards and inserts bubbles; flushes IF/ID on a taken branch.
- Generates EX-stage and ID-stage forwarding selects for the datapath muxes.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/hazard_fwd_unit.sv | 82 ++++++++
 rtl/pipe_ctrl_hazard.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl_hazard.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline control definitions: decoded control bundle, forwarding
// select codes and ALU operation codes used by the decoder and hazard logic.
package pipe_pkg;

    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned FWD_W   = 2;

    typedef struct packed {
        logic               memtoreg;
        logic               memwrite;
        logic               alusrc;
        logic               regdst;
        logic               regw;
        logic               branch;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_NOR  = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 3'b110;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 3'b111;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard detection (load-use, branch operands), branch flush
// and EX/ID forwarding selects. Register 0 never sources a hazard or bypass.
module hazard_fwd_unit
    import pipe_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic             rst,
    input  logic             id_regdst,
    input  logic             id_memwrite,
    input  logic             id_branch,
    input  logic             id_pcsrc,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             ex_memtoreg,
    input  logic             ex_regw,
    input  logic [RA_W-1:0]  ex_rs,
    input  logic [RA_W-1:0]  ex_rt,
    input  logic [RA_W-1:0]  ex_wreg,
    input  logic             mem_memtoreg,
    input  logic             mem_regw,
    input  logic [RA_W-1:0]  mem_wreg,
    input  logic             wb_regw,
    input  logic [RA_W-1:0]  wb_wreg,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             pc_take,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic             fwd_id_a,
    output logic             fwd_id_b
);

    logic uses_rt;
    logic ex_live;
    logic mem_live;
    logic wb_live;
    logic load_use;
    logic branch_hz;

    always_comb begin
        uses_rt  = id_regdst | id_memwrite | id_branch;
        ex_live  = ex_regw & (ex_wreg != '0);
        mem_live = mem_regw & (mem_wreg != '0);
        wb_live  = wb_regw & (wb_wreg != '0);

        load_use  = ex_memtoreg & ex_live &
                    ((ex_wreg == id_rs) | (uses_rt & (ex_wreg == id_rt)));
        // the ID compare can take an ALU result from MEM, but not a load
        branch_hz = id_branch &
                    ((ex_live & ((ex_wreg == id_rs) | (ex_wreg == id_rt))) |
                     (mem_memtoreg & mem_live &
                      ((mem_wreg == id_rs) | (mem_wreg == id_rt))));

        // reset outranks stall, stall outranks the branch flush
        stall      = ~rst & (load_use | branch_hz);
        pc_write   = ~stall;
        ifid_write = ~stall;
        pc_take    = id_pcsrc & ~stall;
        ifid_flush = pc_take & ~rst;

        fwd_a = FWD_RF;
        if (mem_live && (mem_wreg == ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (wb_live && (wb_wreg == ex_rs)) begin
            fwd_a = FWD_WB;
        end

        fwd_b = FWD_RF;
        if (mem_live && (mem_wreg == ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (wb_live && (wb_wreg == ex_rt)) begin
            fwd_b = FWD_WB;
        end

        fwd_id_a = mem_live & ~mem_memtoreg & (mem_wreg == id_rs);
        fwd_id_b = mem_live & ~mem_memtoreg & (mem_wreg == id_rt);
    end

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// Pipeline control: carries the decoded ID bundle through ID/EX, EX/MEM and
// MEM/WB, inserting bubbles on hazards and killing the write of taken branches.
module pipe_ctrl_hazard
    import pipe_pkg::*;
#(
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_memtoreg,
    input  logic               id_memwrite,
    input  logic               id_alusrc,
    input  logic               id_regdst,
    input  logic               id_regw,
    input  logic               id_branch,
    input  logic               id_pcsrc,
    input  logic [2:0]         id_aluop,
    input  logic [RA_W-1:0]    id_rs,
    input  logic [RA_W-1:0]    id_rt,
    input  logic [RA_W-1:0]    id_rd,
    output logic               ex_memtoreg,
    output logic               ex_memwrite,
    output logic               ex_alusrc,
    output logic               ex_regw,
    output logic [2:0]         ex_aluop,
    output logic [RA_W-1:0]    ex_rs,
    output logic [RA_W-1:0]    ex_rt,
    output logic [RA_W-1:0]    ex_wreg,
    output logic               mem_memtoreg,
    output logic               mem_memwrite,
    output logic               mem_regw,
    output logic [RA_W-1:0]    mem_wreg,
    output logic               wb_memtoreg,
    output logic               wb_regw,
    output logic [RA_W-1:0]    wb_wreg,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               pc_take,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               fwd_id_a,
    output logic               fwd_id_b,
    output logic [CNT_W-1:0]   stall_cnt
);

    ctrl_t id_ctrl;
    logic  stall;

    assign id_ctrl = '{memtoreg: id_memtoreg, memwrite: id_memwrite,
                       alusrc: id_alusrc, regdst: id_regdst, regw: id_regw,
                       branch: id_branch, aluop: id_aluop};

    hazard_fwd_unit #(
        .RA_W (RA_W)
    ) u_hazard (
        .rst          (rst),
        .id_regdst    (id_ctrl.regdst),
        .id_memwrite  (id_ctrl.memwrite),
        .id_branch    (id_ctrl.branch),
        .id_pcsrc     (id_pcsrc),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_memtoreg  (ex_memtoreg),
        .ex_regw      (ex_regw),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_wreg      (ex_wreg),
        .mem_memtoreg (mem_memtoreg),
        .mem_regw     (mem_regw),
        .mem_wreg     (mem_wreg),
        .wb_regw      (wb_regw),
        .wb_wreg      (wb_wreg),
        .stall        (stall),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .pc_take      (pc_take),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .fwd_id_a     (fwd_id_a),
        .fwd_id_b     (fwd_id_b)
    );

    // stage registers; a cleared stage is a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_memtoreg  <= 1'b0;
            ex_memwrite  <= 1'b0;
            ex_alusrc    <= 1'b0;
            ex_regw      <= 1'b0;
            ex_aluop     <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_wreg      <= '0;
            mem_memtoreg <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_regw     <= 1'b0;
            mem_wreg     <= '0;
            wb_memtoreg  <= 1'b0;
            wb_regw      <= 1'b0;
            wb_wreg      <= '0;
            stall_cnt    <= '0;
        end else begin
            if (stall) begin
                ex_memtoreg <= 1'b0;
                ex_memwrite <= 1'b0;
                ex_alusrc   <= 1'b0;
                ex_regw     <= 1'b0;
                ex_aluop    <= '0;
                ex_rs       <= '0;
                ex_rt       <= '0;
                ex_wreg     <= '0;
            end else begin
                // a taken branch proceeds but must not write anything
                ex_memtoreg <= id_ctrl.memtoreg;
                ex_memwrite <= id_ctrl.memwrite & ~pc_take;
                ex_alusrc   <= id_ctrl.alusrc;
                ex_regw     <= id_ctrl.regw & ~pc_take;
                ex_aluop    <= id_ctrl.aluop;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_wreg     <= id_ctrl.regdst ? id_rd : id_rt;
            end
            mem_memtoreg <= ex_memtoreg;
            mem_memwrite <= ex_memwrite;
            mem_regw     <= ex_regw;
            mem_wreg     <= ex_wreg;
            wb_memtoreg  <= mem_memtoreg;
            wb_regw      <= mem_regw;
            wb_wreg      <= mem_wreg;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Bench for pipe_ctrl_hazard: directed vector table for the hazard scenarios,
// then random instruction streams checked against an instruction-level model.
module tb_pipe_ctrl_hazard;

    localparam int unsigned RA_W  = 5;
    localparam int unsigned CNT_W = 16;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    // control bundle order: {memtoreg, memwrite, alusrc, regdst, regw, branch, pcsrc}
    localparam bit [6:0] NOP  = 7'b0000000;
    localparam bit [6:0] LW   = 7'b1010100;
    localparam bit [6:0] RT   = 7'b0001100;
    localparam bit [6:0] ADDI = 7'b0010100;
    localparam bit [6:0] BEQT = 7'b0000011;

    logic clk;
    logic rst;
    logic id_memtoreg, id_memwrite, id_alusrc, id_regdst, id_regw, id_branch, id_pcsrc;
    logic [2:0] id_aluop;
    logic [RA_W-1:0] id_rs, id_rt, id_rd;
    logic ex_memtoreg, ex_memwrite, ex_alusrc, ex_regw;
    logic [2:0] ex_aluop;
    logic [RA_W-1:0] ex_rs, ex_rt, ex_wreg;
    logic mem_memtoreg, mem_memwrite, mem_regw;
    logic [RA_W-1:0] mem_wreg;
    logic wb_memtoreg, wb_regw;
    logic [RA_W-1:0] wb_wreg;
    logic pc_write, ifid_write, ifid_flush, pc_take;
    logic [1:0] fwd_a, fwd_b;
    logic fwd_id_a, fwd_id_b;
    logic [CNT_W-1:0] stall_cnt;

    pipe_ctrl_hazard #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
        .id_regdst(id_regdst), .id_regw(id_regw), .id_branch(id_branch),
        .id_pcsrc(id_pcsrc), .id_aluop(id_aluop),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
        .ex_regw(ex_regw), .ex_aluop(ex_aluop),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
        .mem_memtoreg(mem_memtoreg), .mem_memwrite(mem_memwrite),
        .mem_regw(mem_regw), .mem_wreg(mem_wreg),
        .wb_memtoreg(wb_memtoreg), .wb_regw(wb_regw), .wb_wreg(wb_wreg),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .pc_take(pc_take), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one in-flight instruction as seen by the model
    typedef struct {
        bit memtoreg;
        bit memwrite;
        bit alusrc;
        bit regw;
        int aluop;
        int rs;
        int rt;
        int wreg;
    } stage_t;

    typedef struct {
        bit       rst;
        bit [6:0] ctl;
        int       rs, rt, rd;
        int       pcw, flush, take, fa, fb, fida, fidb;
    } vec_t;

    stage_t pipe[$];      // [0] = EX, [1] = MEM, [2] = WB
    int     model_cnt;
    bit     m_stall;
    bit     m_take;
    int     checks;
    int     errors;
    vec_t   tbl[$];

    task automatic chk(string tag, string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0d expected=%0d at %0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic drive(bit r, bit [6:0] ctl, int a, int b, int d);
        rst = r;
        {id_memtoreg, id_memwrite, id_alusrc, id_regdst, id_regw, id_branch, id_pcsrc} = ctl;
        id_aluop = 3'(a + d);
        id_rs    = RA_W'(a);
        id_rt    = RA_W'(b);
        id_rd    = RA_W'(d);
    endtask

    function automatic bit writes(stage_t s, int r);
        return s.regw && (s.wreg != 0) && (s.wreg == r);
    endfunction

    function automatic int bypass(stage_t mem, stage_t wb, int r);
        if (writes(mem, r)) return 2;
        if (writes(wb, r)) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        stage_t z;
        z = '{default: 0};
        pipe.delete();
        repeat (3) pipe.push_back(z);
        model_cnt = 0;
    endtask

    // compare every DUT output against the model, then advance the model one edge
    task automatic cycle_tail(string tag);
        stage_t ex, mem, wb, nw;
        int rs, rt;
        bit uses_rt, load_use, br_hz;
        ex = pipe[0]; mem = pipe[1]; wb = pipe[2];
        rs = int'(id_rs); rt = int'(id_rt);
        uses_rt  = id_regdst || id_memwrite || id_branch;
        load_use = ex.memtoreg && (writes(ex, rs) || (uses_rt && writes(ex, rt)));
        br_hz    = id_branch && (writes(ex, rs) || writes(ex, rt) ||
                   (mem.memtoreg && (writes(mem, rs) || writes(mem, rt))));
        m_stall  = !rst && (load_use || br_hz);
        m_take   = id_pcsrc && !m_stall;

        chk(tag, "pc_write",   int'(pc_write),   int'(!m_stall));
        chk(tag, "ifid_write", int'(ifid_write), int'(!m_stall));
        chk(tag, "pc_take",    int'(pc_take),    int'(m_take));
        chk(tag, "ifid_flush", int'(ifid_flush), int'(m_take && !rst));
        chk(tag, "fwd_a",      int'(fwd_a),      bypass(mem, wb, ex.rs));
        chk(tag, "fwd_b",      int'(fwd_b),      bypass(mem, wb, ex.rt));
        chk(tag, "fwd_id_a",   int'(fwd_id_a),   int'(writes(mem, rs) && !mem.memtoreg));
        chk(tag, "fwd_id_b",   int'(fwd_id_b),   int'(writes(mem, rt) && !mem.memtoreg));
        chk(tag, "ex_memtoreg", int'(ex_memtoreg), int'(ex.memtoreg));
        chk(tag, "ex_memwrite", int'(ex_memwrite), int'(ex.memwrite));
        chk(tag, "ex_alusrc",   int'(ex_alusrc),   int'(ex.alusrc));
        chk(tag, "ex_regw",     int'(ex_regw),     int'(ex.regw));
        chk(tag, "ex_aluop",    int'(ex_aluop),    ex.aluop);
        chk(tag, "ex_rs",       int'(ex_rs),       ex.rs);
        chk(tag, "ex_rt",       int'(ex_rt),       ex.rt);
        chk(tag, "ex_wreg",     int'(ex_wreg),     ex.wreg);
        chk(tag, "mem_memtoreg", int'(mem_memtoreg), int'(mem.memtoreg));
        chk(tag, "mem_memwrite", int'(mem_memwrite), int'(mem.memwrite));
        chk(tag, "mem_regw",     int'(mem_regw),     int'(mem.regw));
        chk(tag, "mem_wreg",     int'(mem_wreg),     mem.wreg);
        chk(tag, "wb_memtoreg",  int'(wb_memtoreg),  int'(wb.memtoreg));
        chk(tag, "wb_regw",      int'(wb_regw),      int'(wb.regw));
        chk(tag, "wb_wreg",      int'(wb_wreg),      wb.wreg);
        chk(tag, "stall_cnt",    int'(stall_cnt),    model_cnt);

        if (rst) begin
            model_reset();
        end else begin
            nw = '{default: 0};
            if (m_stall) begin
                if (model_cnt != CNT_MAX) model_cnt++;
            end else begin
                nw.memtoreg = id_memtoreg;
                nw.memwrite = id_memwrite && !m_take;
                nw.alusrc   = id_alusrc;
                nw.regw     = id_regw && !m_take;
                nw.aluop    = int'(id_aluop);
                nw.rs       = rs;
                nw.rt       = rt;
                nw.wreg     = id_regdst ? int'(id_rd) : rt;
            end
            pipe.push_front(nw);
            void'(pipe.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit r, bit [6:0] ctl, int a, int b, int d,
                                int pcw, int flush, int take, int fa, int fb,
                                int fida, int fidb);
        vec_t v;
        v.rst = r; v.ctl = ctl; v.rs = a; v.rt = b; v.rd = d;
        v.pcw = pcw; v.flush = flush; v.take = take;
        v.fa = fa; v.fb = fb; v.fida = fida; v.fidb = fidb;
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        //               rst ctl   rs rt rd  pcw fl tk fa fb fia fib
        tbl.push_back(mk(0, LW,    1, 2, 0,  1, 0, 0, 0, 0, 0, 0)); // lw $2
        tbl.push_back(mk(0, RT,    2, 5, 4,  0, 0, 0, 0, 0, 0, 0)); // add uses $2: stall
        tbl.push_back(mk(0, RT,    2, 5, 4,  1, 0, 0, 0, 0, 0, 0)); // retry, bubble in EX
        tbl.push_back(mk(0, RT,    4, 7, 6,  1, 0, 0, 1, 0, 0, 0)); // add in EX: $2 from WB
        tbl.push_back(mk(0, RT,    9, 4, 8,  1, 0, 0, 2, 0, 0, 1)); // sub reads $4 from MEM
        tbl.push_back(mk(0, NOP,   0, 0, 0,  1, 0, 0, 0, 1, 0, 0)); // or rt=$4 from WB
        tbl.push_back(mk(0, ADDI,  0, 5, 0,  1, 0, 0, 0, 0, 0, 0)); // addi $5
        tbl.push_back(mk(0, ADDI,  0, 5, 0,  1, 0, 0, 0, 0, 0, 0)); // addi $5 again
        tbl.push_back(mk(0, RT,    5, 0, 10, 1, 0, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, NOP,   0, 0, 0,  1, 0, 0, 2, 0, 0, 0)); // MEM beats WB on $5
        tbl.push_back(mk(0, BEQT,  1, 3, 0,  1, 1, 1, 0, 0, 0, 0)); // taken, no hazard
        tbl.push_back(mk(0, ADDI,  0, 4, 0,  1, 0, 0, 0, 0, 0, 0)); // addi $4
        tbl.push_back(mk(0, BEQT,  4, 6, 0,  0, 0, 0, 0, 0, 0, 0)); // branch on $4: stall
        tbl.push_back(mk(0, BEQT,  4, 6, 0,  1, 1, 1, 0, 0, 1, 0)); // resolves with ID bypass
        tbl.push_back(mk(0, LW,    1, 0, 0,  1, 0, 0, 1, 0, 0, 0)); // lw $0
        tbl.push_back(mk(0, RT,    0, 0, 7,  1, 0, 0, 0, 0, 0, 0)); // $0 is never a hazard
        tbl.push_back(mk(0, NOP,   0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, LW,    0, 3, 0,  1, 0, 0, 0, 0, 0, 0)); // lw $3
        tbl.push_back(mk(0, RT,    3, 0, 9,  0, 0, 0, 0, 0, 0, 0)); // stall
        tbl.push_back(mk(0, RT,    3, 0, 9,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, LW,    0, 2, 0,  1, 0, 0, 1, 0, 0, 0)); // $3 from WB
        tbl.push_back(mk(1, RT,    2, 0, 11, 1, 0, 0, 0, 0, 0, 0)); // reset in a stall cycle
        tbl.push_back(mk(0, RT,    2, 0, 11, 1, 0, 0, 0, 0, 0, 0)); // hazard gone after reset
        tbl.push_back(mk(1, BEQT,  0, 0, 0,  1, 0, 1, 0, 0, 0, 0)); // reset: take follows pcsrc

        drive(1'b1, NOP, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].rst, tbl[i].ctl, tbl[i].rs, tbl[i].rt, tbl[i].rd);
            @(negedge clk);
            chk(tag, "tbl_pc_write", int'(pc_write),   tbl[i].pcw);
            chk(tag, "tbl_flush",    int'(ifid_flush), tbl[i].flush);
            chk(tag, "tbl_take",     int'(pc_take),    tbl[i].take);
            chk(tag, "tbl_fwd_a",    int'(fwd_a),      tbl[i].fa);
            chk(tag, "tbl_fwd_b",    int'(fwd_b),      tbl[i].fb);
            chk(tag, "tbl_fwd_id_a", int'(fwd_id_a),   tbl[i].fida);
            chk(tag, "tbl_fwd_id_b", int'(fwd_id_b),   tbl[i].fidb);
            cycle_tail(tag);
        end

        // stall counter after the directed run: reset cleared it, no stall since
        drive(1'b0, NOP, 0, 0, 0);
        @(negedge clk);
        chk("post_tbl", "stall_cnt_zero", int'(stall_cnt), 0);
        cycle_tail("post_tbl");

        // random streams on a small register window to provoke frequent hazards
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 79) == 0, 7'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
            @(negedge clk);
            cycle_tail("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
